cardinal_vc_out_arbiter: RTL and testbench
==========================================

// Module: cardinal_vc_out_arbiter
// PURPOSE
//  Output-port scheduler for one Cardinal ring router link. Arbitrates NUM_REQ
//  packet sources (ring pass-through inputs, local NIC injection) onto one
//  output link, with one single-entry buffer per virtual channel (VC0 even, VC1 odd).
//  Link handshake matches the cardinal_nic (so/ro, global net polarity), so the
//  block drops between router inputs and a neighbour's net_si/net_ri.
// PARAMETERS
//  PACKET_SIZE  64  packet width; bit [0] is the VC bit (MSB, [0:N-1] order)
//  NUM_REQ      3   number of requesters (>=2)
//  PTR_W        2   round-robin pointer width, >= clog2(NUM_REQ)
// PORTS
//  clk        in   1                     rising-edge clock
//  reset      in   1                     asynchronous, active-high reset
//  polarity   in   1                     global net polarity; toggles every cycle
//  req        in   NUM_REQ               req[i]=1: requester i holds a valid packet
//  req_data   in   NUM_REQ*PACKET_SIZE   requester i at [i*PACKET_SIZE +: PACKET_SIZE]
//  gnt        out  NUM_REQ               one-hot grant, combinational, same cycle
//  out_so     out  1                     registered send strobe to link
//  out_ro     in   1                     downstream ready to accept
//  out_do     out  PACKET_SIZE           registered packet to link
//  buf_full   out  2                     [v]=1: VC v buffer occupied
// BEHAVIOUR
//  - Reset (async): out_so=0, out_do=0, buf_full=00, both RR pointers=0. Buffered
//    packets are discarded; gnt=0 while reset=1.
//  - Let p = polarity sampled just before the edge. Each cycle:
//    * Fill phase, VC ~p: requester i eligible iff req[i] && req_data_i[0]==~p
//      && buf_full[~p]==0. Highest-priority eligible gets gnt[i]=1; at the edge
//      buffer[~p] <= req_data_i, buf_full[~p] <= 1.
//    * Send phase, VC p: if buf_full[p] && out_ro, at the edge out_so<=1,
//      out_do<=buffer[p], buf_full[p]<=0. Otherwise out_so<=0, out_do holds.
//  - Fill and send always target different VCs: no same-buffer read/write race.
//  - out_so is a 1-cycle pulse; sends occur at most every other cycle per VC.
//  - Requester must hold req/req_data stable until the cycle gnt[i]=1; it
//    deasserts or presents the next packet after that edge.
//  - Round robin, separate pointer per VC: search starts at ptr[v], wraps at
//    NUM_REQ-1 -> 0. After a grant, ptr[v] <= (winner+1) mod NUM_REQ. No grant
//    -> pointer holds. Pointer values >= NUM_REQ never occur.
//  - Back-pressure: out_ro=0 keeps buffer[p] full; that VC's requesters get no
//    grants until it drains. Other VC is unaffected.
//  - Latency: grant edge to out_so edge = 1 cycle minimum (next cycle with
//    polarity==v and out_ro=1).
//  - req with wrong VC for the current fill phase is not an error; it waits.
// TESTING
//  1 reset=1 mid-run with buf_full=11 -> out_so=0, gnt=0, buf_full=00 at once; the
//    discarded packets never appear on out_do after release.
//  2 req=001, data0 VC0 payload 5, polarity=1 -> gnt=001 that cycle; next cycle
//    (polarity 0, out_ro=1) -> out_so=1, out_do[32:63]=5 for exactly 1 cycle.
//  3 req=111 all VC0 held, refresh data after each grant, out_ro=1 -> VC0 grant
//    order 0,1,2,0,1,2; one out_so every 2 cycles, payloads in that order.
//  4 req=001 data0 VC1 while polarity=1 -> gnt=000; following cycle (polarity 0)
//    -> gnt=001; out_so on the next polarity=1 edge.
//  5 buf_full[0]=1, out_ro=0 for 6 cycles, req=010 VC0 -> no gnt, out_so=0;
//    VC1 traffic on req0 still flows; raise out_ro -> VC0 sends at first p=0 edge,
//    req1 granted on the following p=1 cycle.
//  6 Mixed: req0 VC0 payloads 0..7, req1 VC1 payloads 100..107 -> all 16 on link,
//    per-VC order preserved, no duplicates, no losses.

Source files
------------

// File: rtl/cardinal_vc_out_arbiter.sv
// -----------------------------------------------------------------------------
// cardinal_vc_out_arbiter
//
// Output-port scheduler for one Cardinal ring router link. NUM_REQ packet
// sources (ring pass-through inputs, local NIC injection) compete for one
// output link. Each virtual channel (VC0 = even, VC1 = odd) owns a
// single-entry buffer. The global net polarity splits every cycle into two
// phases that always work on different VCs:
//   fill phase (VC ~polarity): round-robin pick of one requester whose packet
//                              carries that VC, written into the empty buffer
//   send phase (VC  polarity): the buffered packet goes out on the link when
//                              the downstream side is ready
// Because fill and send never touch the same VC in one cycle, a buffer is
// never read and written on the same edge.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   polarity  in   global net polarity, toggles every cycle
//   req       in   [NUM_REQ]              requester i holds a valid packet
//   req_data  in   [NUM_REQ*PACKET_SIZE]  requester i at [i*PACKET_SIZE +: PACKET_SIZE]
//   gnt       out  [NUM_REQ]              one-hot grant, combinational
//   out_so    out  registered 1-cycle send strobe to the link
//   out_ro    in   downstream ready
//   out_do    out  [PACKET_SIZE]          registered packet to the link
//   buf_full  out  [2]                    per-VC buffer occupancy
//
// Packets use [0:PACKET_SIZE-1] ordering; bit [0] (the MSB) is the VC bit.
// -----------------------------------------------------------------------------
module cardinal_vc_out_arbiter #(
  parameter int PACKET_SIZE = 64,
  parameter int NUM_REQ     = 3,
  parameter int PTR_W       = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             polarity,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [0:NUM_REQ*PACKET_SIZE-1]   req_data,
  output logic [NUM_REQ-1:0]               gnt,
  output logic                             out_so,
  input  logic                             out_ro,
  output logic [0:PACKET_SIZE-1]           out_do,
  output logic [1:0]                       buf_full
);

  // Wrap a candidate index back into 0..NUM_REQ-1. The operand is always a
  // pointer (< NUM_REQ) plus an offset (< NUM_REQ), so one subtraction is
  // enough; the extra top bit keeps the sum from overflowing.
  function automatic logic [PTR_W:0] rr_wrap(input logic [PTR_W:0] v);
    if (v >= (PTR_W+1)'(NUM_REQ)) begin
      return v - (PTR_W+1)'(NUM_REQ);
    end
    return v;
  endfunction

  // Successor of the winning requester, modulo NUM_REQ.
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] w);
    if (w == PTR_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return w + PTR_W'(1);
  endfunction

  logic                     fill_vc;
  logic                     send_vc;
  logic [0:PACKET_SIZE-1]   pkt      [NUM_REQ];
  logic [NUM_REQ-1:0]       pkt_vc;
  logic [NUM_REQ-1:0]       elig;
  logic [PTR_W-1:0]         rr_ptr   [2];
  logic [PTR_W:0]           cand;
  logic                     grant_vld;
  logic [PTR_W-1:0]         win_idx;
  logic [PTR_W-1:0]         win_next;
  logic [0:PACKET_SIZE-1]   fill_data;
  logic [0:PACKET_SIZE-1]   vc_buf   [2];

  assign fill_vc = ~polarity;
  assign send_vc = polarity;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign pkt[g]    = req_data[g*PACKET_SIZE +: PACKET_SIZE];
      assign pkt_vc[g] = pkt[g][0];
    end
  endgenerate

  // ---- fill phase: eligibility and round-robin arbitration -----------------
  // A requester competes only when its packet belongs to the VC being filled
  // this cycle and that VC's buffer is free. Reset forces the grant vector to
  // zero so nothing is consumed while the block is held in reset.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req[i] && (pkt_vc[i] == fill_vc) && !buf_full[fill_vc] && !reset;
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_wrap({1'b0, rr_ptr[fill_vc]} + (PTR_W+1)'(k));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_vld && elig[i] && (cand == (PTR_W+1)'(i))) begin
          grant_vld = 1'b1;
          win_idx   = PTR_W'(i);
        end
      end
    end
  end

  always_comb begin
    gnt       = '0;
    fill_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = grant_vld && (win_idx == PTR_W'(i));
      if (gnt[i]) begin
        fill_data = pkt[i];
      end
    end
  end

  assign win_next = rr_next(win_idx);

  // ---- buffer write: packet data, no reset needed -------------------------
  // Occupancy is tracked by buf_full; stale contents are never sent because
  // a send requires the full flag, which reset clears.
  always_ff @(posedge clk) begin
    if (grant_vld) begin
      vc_buf[fill_vc] <= fill_data;
    end
  end

  // ---- control state and link output register ------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_full  <= 2'b00;
      rr_ptr[0] <= '0;
      rr_ptr[1] <= '0;
      out_so    <= 1'b0;
      out_do    <= '0;
    end else begin
      if (grant_vld) begin
        buf_full[fill_vc] <= 1'b1;
        rr_ptr[fill_vc]   <= win_next;
      end
      // Send phase: drain the buffer of the polarity VC if the link is ready;
      // otherwise the strobe drops and the data lines hold their last value.
      if (buf_full[send_vc] && out_ro) begin
        buf_full[send_vc] <= 1'b0;
        out_so            <= 1'b1;
        out_do            <= vc_buf[send_vc];
      end else begin
        out_so <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cardinal_vc_out_arbiter.sv
module tb_cardinal_vc_out_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic             polarity;
  logic [2:0]       req;
  logic [0:191]     req_data;
  logic [2:0]       gnt;
  logic             out_so;
  logic             out_ro;
  logic [0:63]      out_do;
  logic [1:0]       buf_full;

  int checks = 0;
  int errors = 0;

  cardinal_vc_out_arbiter #(
    .PACKET_SIZE(64),
    .NUM_REQ(3),
    .PTR_W(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .polarity(polarity),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .out_so(out_so),
    .out_ro(out_ro),
    .out_do(out_do),
    .buf_full(buf_full)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  function automatic logic [0:63] mk(input logic vc, input logic [31:0] pl);
    logic [0:63] p;
    p        = '0;
    p[0]     = vc;
    p[32:63] = pl;
    return p;
  endfunction

  task automatic set_data(input int i, input logic [0:63] p);
    req_data[i*64 +: 64] = p;
  endtask

  // Advance one clock; polarity flips right after each edge like the net.
  task automatic tick();
    @(posedge clk);
    #1;
    polarity = ~polarity;
    #1;
  endtask

  task automatic align(input logic v);
    if (polarity !== v) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; polarity = 1'b0; out_ro = 1'b0;
    for (int i = 0; i < 3; i++) set_data(i, mk(1'b1, 32'(i)));
    req = 3'b111;
    tick(); tick();
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rst_gnt got %b exp %b", gnt, 3'b000); end
    checks++; if (out_so !== 1'b0) begin errors++; $display("FAIL rst_so got %b exp 0", out_so); end
    checks++; if (buf_full !== 2'b00) begin errors++; $display("FAIL rst_buf got %b exp 00", buf_full); end
    checks++; if (out_do !== 64'h0) begin errors++; $display("FAIL rst_do got %h exp 0", out_do); end
    req = 3'b000;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    out_ro = 1'b1;
    align(1'b1);
    set_data(0, mk(1'b0, 32'd5));
    req = 3'b001;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL single_gnt got %b exp 001", gnt); end
    tick();
    req = 3'b000;
    #1;
    checks++; if (out_so !== 1'b0) begin errors++; $display("FAIL single_so_early got %b exp 0", out_so); end
    checks++; if (buf_full !== 2'b01) begin errors++; $display("FAIL single_buf got %b exp 01", buf_full); end
    tick();
    checks++; if (out_so !== 1'b1) begin errors++; $display("FAIL single_so got %b exp 1", out_so); end
    checks++; if (out_do[32:63] !== 32'd5) begin errors++; $display("FAIL single_do got %h exp 5", out_do[32:63]); end
    checks++; if (buf_full !== 2'b00) begin errors++; $display("FAIL single_buf_drain got %b exp 00", buf_full); end
    tick();
    checks++; if (out_so !== 1'b0) begin errors++; $display("FAIL single_so_pulse got %b exp 0", out_so); end
  endtask

  task automatic test_reset_midrun();
    out_ro = 1'b0;
    align(1'b1);
    set_data(0, mk(1'b0, 32'hAA));
    req = 3'b001;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL mid_gnt0 got %b exp 001", gnt); end
    tick();
    set_data(0, mk(1'b1, 32'hBB));
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL mid_gnt1 got %b exp 001", gnt); end
    tick();
    set_data(0, mk(1'b0, 32'hCC));
    #1;
    checks++; if (buf_full !== 2'b11) begin errors++; $display("FAIL mid_full got %b exp 11", buf_full); end
    reset = 1'b1;
    #1;
    checks++; if (buf_full !== 2'b00) begin errors++; $display("FAIL mid_rst_buf got %b exp 00", buf_full); end
    checks++; if (out_so !== 1'b0) begin errors++; $display("FAIL mid_rst_so got %b exp 0", out_so); end
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL mid_rst_gnt got %b exp 000", gnt); end
    checks++; if (out_do !== 64'h0) begin errors++; $display("FAIL mid_rst_do got %h exp 0", out_do); end
    tick();
    reset = 1'b0;
    req = 3'b000;
    out_ro = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (out_so !== 1'b0) begin errors++; $display("FAIL mid_discard_so got %b exp 0 cycle %0d", out_so, c); end
    end
  endtask

  task automatic test_rr();
    int cnt [3];
    int w;
    logic [31:0] prev_pl;
    prev_pl = '0;
    out_ro = 1'b1;
    align(1'b1);
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0;
      set_data(i, mk(1'b0, 32'(16*i)));
    end
    req = 3'b111;
    #1;
    for (int g = 0; g < 6; g++) begin
      w = g % 3;
      if (g > 0) begin
        checks++; if (out_so !== 1'b1) begin errors++; $display("FAIL rr_so got %b exp 1 grant %0d", out_so, g); end
        checks++; if (out_do[32:63] !== prev_pl) begin errors++; $display("FAIL rr_do got %h exp %h", out_do[32:63], prev_pl); end
      end
      checks++; if (gnt !== (3'b001 << w)) begin errors++; $display("FAIL rr_gnt got %b exp %b", gnt, 3'b001 << w); end
      tick();
      cnt[w]++;
      prev_pl = 32'(16*w + cnt[w] - 1);
      set_data(w, mk(1'b0, 32'(16*w + cnt[w])));
      #1;
      checks++; if (out_so !== 1'b0) begin errors++; $display("FAIL rr_so_gap got %b exp 0", out_so); end
      checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rr_gnt_gap got %b exp 000", gnt); end
      tick();
      #1;
    end
    checks++; if (out_so !== 1'b1) begin errors++; $display("FAIL rr_so_last got %b exp 1", out_so); end
    checks++; if (out_do[32:63] !== prev_pl) begin errors++; $display("FAIL rr_do_last got %h exp %h", out_do[32:63], prev_pl); end
    req = 3'b000;
    tick();
  endtask

  task automatic test_wrong_vc();
    out_ro = 1'b1;
    align(1'b1);
    set_data(0, mk(1'b1, 32'd7));
    req = 3'b001;
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL wvc_gnt_wait got %b exp 000", gnt); end
    tick();
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL wvc_gnt got %b exp 001", gnt); end
    tick();
    req = 3'b000;
    #1;
    checks++; if (buf_full !== 2'b10) begin errors++; $display("FAIL wvc_buf got %b exp 10", buf_full); end
    checks++; if (out_so !== 1'b0) begin errors++; $display("FAIL wvc_so_early got %b exp 0", out_so); end
    tick();
    checks++; if (out_so !== 1'b1) begin errors++; $display("FAIL wvc_so got %b exp 1", out_so); end
    checks++; if (out_do !== mk(1'b1, 32'd7)) begin errors++; $display("FAIL wvc_do got %h exp %h", out_do, mk(1'b1, 32'd7)); end
  endtask

  task automatic test_backpressure();
    out_ro = 1'b0;
    align(1'b1);
    set_data(2, mk(1'b0, 32'h20));
    req = 3'b100;
    #1;
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL bp_fill_gnt got %b exp 100", gnt); end
    tick();
    set_data(1, mk(1'b0, 32'h21));
    set_data(0, mk(1'b1, 32'h30));
    req = 3'b011;
    for (int j = 0; j < 3; j++) begin
      out_ro = 1'b0;
      #1;
      checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL bp_vc1_gnt got %b exp 001", gnt); end
      checks++; if (buf_full[0] !== 1'b1) begin errors++; $display("FAIL bp_vc0_held got %b exp 1", buf_full[0]); end
      if (j > 0) begin
        checks++; if (out_so !== 1'b1) begin errors++; $display("FAIL bp_vc1_so got %b exp 1", out_so); end
        checks++; if (out_do !== mk(1'b1, 32'(32'h30 + j - 1))) begin errors++; $display("FAIL bp_vc1_do got %h exp %h", out_do, mk(1'b1, 32'(32'h30 + j - 1))); end
      end else begin
        checks++; if (out_so !== 1'b0) begin errors++; $display("FAIL bp_so_first got %b exp 0", out_so); end
      end
      tick();
      set_data(0, mk(1'b1, 32'(32'h30 + j + 1)));
      out_ro = 1'b1;
      #1;
      checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL bp_vc0_blocked got %b exp 000", gnt); end
      checks++; if (out_so !== 1'b0) begin errors++; $display("FAIL bp_so_stall got %b exp 0", out_so); end
      tick();
    end
    checks++; if (out_so !== 1'b1) begin errors++; $display("FAIL bp_vc1_so_last got %b exp 1", out_so); end
    checks++; if (out_do[32:63] !== 32'h32) begin errors++; $display("FAIL bp_vc1_do_last got %h exp 32", out_do[32:63]); end
    req = 3'b010;
    out_ro = 1'b1;
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL bp_gnt_p0 got %b exp 000", gnt); end
    tick();
    checks++; if (out_so !== 1'b1) begin errors++; $display("FAIL bp_drain_so got %b exp 1", out_so); end
    checks++; if (out_do !== mk(1'b0, 32'h20)) begin errors++; $display("FAIL bp_drain_do got %h exp %h", out_do, mk(1'b0, 32'h20)); end
    checks++; if (buf_full[0] !== 1'b0) begin errors++; $display("FAIL bp_drain_buf got %b exp 0", buf_full[0]); end
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL bp_req1_gnt got %b exp 010", gnt); end
    tick();
    req = 3'b000;
    #1;
    checks++; if (buf_full !== 2'b01) begin errors++; $display("FAIL bp_req1_buf got %b exp 01", buf_full); end
    tick();
    checks++; if (out_so !== 1'b1) begin errors++; $display("FAIL bp_req1_so got %b exp 1", out_so); end
    checks++; if (out_do[32:63] !== 32'h21) begin errors++; $display("FAIL bp_req1_do got %h exp 21", out_do[32:63]); end
  endtask

  task automatic test_mixed();
    int n0, n1, r0, r1;
    logic [2:0] g;
    logic [31:0] pl;
    n0 = 0; n1 = 0; r0 = 0; r1 = 0;
    out_ro = 1'b1;
    set_data(0, mk(1'b0, 32'd0));
    set_data(1, mk(1'b1, 32'd100));
    req = 3'b011;
    for (int c = 0; c < 80 && (r0 < 8 || r1 < 8); c++) begin
      #1;
      g = gnt;
      tick();
      if (g[0]) begin
        n0++;
        if (n0 < 8) set_data(0, mk(1'b0, 32'(n0))); else req[0] = 1'b0;
      end
      if (g[1]) begin
        n1++;
        if (n1 < 8) set_data(1, mk(1'b1, 32'(100 + n1))); else req[1] = 1'b0;
      end
      if (out_so === 1'b1) begin
        pl = out_do[32:63];
        if (out_do[0] === 1'b0) begin
          checks++; if (pl !== 32'(r0)) begin errors++; $display("FAIL mix_vc0_do got %0d exp %0d", pl, r0); end
          r0++;
        end else begin
          checks++; if (pl !== 32'(100 + r1)) begin errors++; $display("FAIL mix_vc1_do got %0d exp %0d", pl, 100 + r1); end
          r1++;
        end
      end
    end
    checks++; if (r0 !== 8) begin errors++; $display("FAIL mix_vc0_count got %0d exp 8", r0); end
    checks++; if (r1 !== 8) begin errors++; $display("FAIL mix_vc1_count got %0d exp 8", r1); end
    req = 3'b000;
    tick(); tick();
    checks++; if (out_so !== 1'b0) begin errors++; $display("FAIL mix_no_dup got %b exp 0", out_so); end
  endtask

  initial begin
    req_data = '0;
    test_reset();
    test_single();
    test_reset_midrun();
    test_rr();
    test_wrong_vc();
    test_backpressure();
    test_mixed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
